mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter W, default 32 (`WORD_LEN`), data and address width in bits.
REQ-002 Parameter LAT, default 2, memory access cycles per transaction; legal range 1..15.
REQ-003 Clock is clk; one clock; reset is synchronous and active-high, port rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 p0_req  input  1  port 0 (data/MEM stage) request; held high until p0_ack.
REQ-007 p0_we  input  1  port 0 write (1) / read (0).
REQ-008 p0_addr  input  W  port 0 byte address.
REQ-009 p0_wdata  input  W  port 0 write data.
REQ-010 p0_ack  output  1  one-cycle completion pulse for port 0.
REQ-011 p0_rdata  output  W  port 0 read data; valid while p0_ack=1.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same directions/widths/meanings as the port 0 signals, for port 1 (instruction fetch).
REQ-013 m_addr  output  W  address to shared memory.
REQ-014 m_wdata  output  W  write data to shared memory.
REQ-015 m_we  output  1  memory write enable; memory writes on rising clk.
REQ-016 m_re  output  1  memory read enable.
REQ-017 m_rdata  input  W  memory read data.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; one transaction in flight at most.
REQ-020 IDLE: if any req high, latch winner's we/addr/wdata and the winner id; go to ACCESS with counter = LAT-1; else stay IDLE.
REQ-021 Arbitration is round-robin: both requesting -> grant the port not granted last; last-grant bit resets to port 1, so port 0 wins the first contention after reset.
REQ-022 Single requester wins regardless of last-grant bit; back-to-back grants to the same port allowed.
REQ-023 ACCESS: m_addr/m_wdata drive latched values; m_re = ~latched we; m_we = latched we only in the first ACCESS cycle.
REQ-024 ACCESS: counter decrements each cycle; at counter 0, capture m_rdata into the read register and go to DONE.
REQ-025 DONE: winner's ack = 1 for exactly one cycle, its rdata = captured value (write: rdata = 0); go to IDLE.
REQ-026 Latency: req high in IDLE at cycle N -> ack at cycle N+LAT+1; next grant evaluated at cycle N+LAT+2.
REQ-027 Requests and port inputs changing after grant are ignored until the transaction completes; dropping req mid-transaction does not cancel it and ack still pulses.
REQ-028 A requester seeing its ack deasserts req in the following cycle; a req still high in IDLE is a new request.
REQ-029 Outside ACCESS: m_we = 0, m_re = 0, m_addr = 0, m_wdata = 0.
REQ-030 Non-winner ack stays 0 and its rdata holds 0 at all times except during its own ack.
REQ-031 Address passes through unmodified; word selection (addr[17:2]) remains the memory's responsibility.

Reset
REQ-032 rst high on a rising edge: state=IDLE, counter=0, last-grant=port 1, read register=0, all acks 0, all rdata 0, m_we=m_re=0, m_addr=m_wdata=0, busy=0.
REQ-033 rst has priority over all transitions; reset mid-ACCESS aborts with no ack; a write whose m_we cycle already passed remains in memory.

Verification
REQ-034 LAT=2, p1 read addr 0x0000_0010, mem word 4 = 0x2402_0005 -> m_re high 2 cycles, p1_ack at request cycle +3, p1_rdata=0x2402_0005.
REQ-035 p0 write addr 0x0000_0020 data 0xDEAD_BEEF then p0 read same addr -> m_we high exactly 1 cycle, read returns 0xDEAD_BEEF, p0_rdata=0 on write ack.
REQ-036 p0_req and p1_req high together for 4 transactions after reset -> grant order p0, p1, p0, p1; never two acks in one cycle.
REQ-037 rst asserted in second ACCESS cycle of a p1 read -> no p1_ack, busy=0 next cycle, all memory outputs 0.
REQ-038 LAT=1, p1 continuous requests (req re-asserted after each ack) -> ack every 3 cycles, busy low one cycle between transactions.
REQ-039 p0 drops req after grant -> transaction completes, p0_ack still pulses once at grant +LAT+1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sharing one memory port
// One transaction in flight; fixed LAT access cycles followed by a one-cycle ack.
module mem_arbiter #(
    parameter int W = 32,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [W-1:0] p0_addr,
    input  logic [W-1:0] p0_wdata,
    output logic         p0_ack,
    output logic [W-1:0] p0_rdata,
    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [W-1:0] p1_addr,
    input  logic [W-1:0] p1_wdata,
    output logic         p1_ack,
    output logic [W-1:0] p1_rdata,
    output logic [W-1:0] m_addr,
    output logic [W-1:0] m_wdata,
    output logic         m_we,
    output logic         m_re,
    input  logic [W-1:0] m_rdata,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic last, id, pick1;
    // Port 1 wins when it is alone, or when both ask and port 0 was served last.
    assign pick1 = p1_req & (~p0_req | ~last);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            id       <= 1'b0;
            busy     <= 1'b0;
            m_we     <= 1'b0;
            m_re     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (p0_req | p1_req) begin
                    state   <= ACCESS;
                    busy    <= 1'b1;
                    cnt     <= 4'(LAT - 1);
                    id      <= pick1;
                    last    <= pick1;
                    m_we    <= pick1 ? p1_we : p0_we;
                    m_re    <= ~(pick1 ? p1_we : p0_we);
                    m_addr  <= pick1 ? p1_addr : p0_addr;
                    m_wdata <= pick1 ? p1_wdata : p0_wdata;
                end
                ACCESS: begin
                    m_we <= 1'b0;
                    if (cnt == 4'd0) begin
                        state    <= DONE;
                        m_re     <= 1'b0;
                        m_addr   <= '0;
                        m_wdata  <= '0;
                        p0_ack   <= ~id;
                        p1_ack   <= id;
                        p0_rdata <= (~id & m_re) ? m_rdata : '0;
                        p1_rdata <= (id & m_re) ? m_rdata : '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    p0_ack   <= 1'b0;
                    p1_ack   <= 1'b0;
                    p0_rdata <= '0;
                    p1_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic on both ports, scoreboard against a
// transaction-level model of grants, latency and memory contents.
module tb_mem_arbiter;
    localparam int W = 32;
    localparam int LAT = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [W-1:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic p0_ack, p1_ack, m_we, m_re, busy;
    logic [W-1:0] p0_rdata, p1_rdata, m_addr, m_wdata, m_rdata;

    mem_arbiter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
        .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_f(input logic [7:0] i);
        return (i == 8'd4) ? 32'h2402_0005 : {i, 8'hA5, ~i, i ^ 8'h3C};
    endfunction

    // Shared memory: combinational read, write on rising edge; unwritten words read init_f.
    logic [W-1:0] mem [256];
    logic [255:0] wr = '0;
    always @(posedge clk) if (m_we) begin
        mem[m_addr[9:2]] <= m_wdata;
        wr[m_addr[9:2]]  <= 1'b1;
    end
    assign m_rdata = wr[m_addr[9:2]] ? mem[m_addr[9:2]] : init_f(m_addr[9:2]);

    int cyc = 0, n_chk = 0, n_pass = 0, nwe = 0, nre = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    typedef struct {int port; logic [W-1:0] data; int cyc;} exp_t;
    exp_t sb[$];
    int glog[$];
    int gcnt[2] = '{0, 0};
    logic [W-1:0] ref_mem [256];
    int free_at = 0, cur_g = -100;
    logic cur_we = 1'b0;
    logic [W-1:0] cur_addr = '0, cur_wdata = '0;
    bit last_m = 1'b1, armed = 1'b0;

    // Monitor then model, in one process so grants never race the checks.
    always @(negedge clk) begin
        exp_t e;
        int w, idx;
        bit in_acc;
        if (armed) begin
            in_acc = cyc > cur_g && cyc <= cur_g + LAT;
            chk("busy", W'(busy), W'(cyc < free_at));
            chk("m_ctl", W'({m_we, m_re}), in_acc ? W'({cur_we && cyc == cur_g + 1, !cur_we}) : '0);
            chk("m_addr", m_addr, in_acc ? cur_addr : '0);
            chk("m_wdata", m_wdata, in_acc ? cur_wdata : '0);
            chk("ack_both", W'(p0_ack & p1_ack), '0);
            if (p0_ack || p1_ack) begin
                if (sb.size() == 0) chk("ack_unexpected", W'({p1_ack, p0_ack}), '0);
                else begin
                    e = sb.pop_front();
                    chk("ack_port", W'(p1_ack), W'(e.port));
                    chk("ack_cycle", W'(cyc), W'(e.cyc));
                    chk("ack_rdata", p1_ack ? p1_rdata : p0_rdata, e.data);
                    chk("other_rdata", p1_ack ? p0_rdata : p1_rdata, '0);
                end
            end else begin
                chk("rdata_quiet", p0_rdata | p1_rdata, '0);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    chk("ack_missing", W'(p0_ack | p1_ack), W'(1));
                    void'(sb.pop_front());
                end
            end
            nwe += int'(m_we);
            nre += int'(m_re);
        end
        if (rst) begin
            if (!armed) for (int i = 0; i < 256; i++) ref_mem[i] = init_f(8'(i));
            sb.delete();
            free_at = cyc + 1;
            cur_g = -100;
            last_m = 1'b1;
            armed = 1'b1;
        end else if (armed && cyc >= free_at && (p0_req || p1_req)) begin
            w = (p0_req && p1_req) ? (last_m ? 0 : 1) : (p1_req ? 1 : 0);
            cur_we = w == 1 ? p1_we : p0_we;
            cur_addr = w == 1 ? p1_addr : p0_addr;
            cur_wdata = w == 1 ? p1_wdata : p0_wdata;
            idx = int'(cur_addr[9:2]);
            e.port = w;
            e.data = cur_we ? '0 : ref_mem[idx];
            e.cyc = cyc + LAT + 1;
            sb.push_back(e);
            if (cur_we) ref_mem[idx] = cur_wdata;
            cur_g = cyc;
            free_at = cyc + LAT + 2;
            last_m = w == 1;
            gcnt[w]++;
            glog.push_back(w);
        end
    end

    task automatic drive(input int p, input logic r, input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
        if (p == 0) begin p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; end
        else begin p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; end
    endtask

    // One request: hold until ack (or drop/scramble inputs once granted), then release.
    task automatic xact(input int p, input logic we, input logic [W-1:0] a, input logic [W-1:0] d,
                        input bit drop, output logic [W-1:0] rd, output int t_req, output int t_ack);
        int g0;
        bit sg;
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        t_req = cyc; g0 = gcnt[p]; sg = 1'b0; t_ack = -1; rd = '0;
        for (int k = 0; k < 100 && t_ack < 0; k++) begin
            @(negedge clk);
            if (p == 0 ? p0_ack : p1_ack) begin
                t_ack = cyc;
                rd = p == 0 ? p0_rdata : p1_rdata;
            end else if (!sg && gcnt[p] != g0) begin
                sg = 1'b1;
                @(posedge clk); #1;
                drive(p, !drop, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
        end
        if (t_ack < 0) chk("xact_timeout", W'(p == 0 ? p0_ack : p1_ack), W'(1));
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        int tr, ta, n0, g0, acks[3], na;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_acks", W'({p0_ack, p1_ack}), '0);
        chk("rst_rdata", p0_rdata | p1_rdata, '0);
        chk("rst_mctl", W'({m_we, m_re}), '0);
        chk("rst_maddr", m_addr | m_wdata, '0);
        @(posedge clk); #1 rst = 1'b0;

        n0 = nre;
        xact(1, 1'b0, 32'h0000_0010, '0, 1'b0, rd, tr, ta);
        chk("p1_read_data", rd, 32'h2402_0005);
        chk("p1_read_lat", W'(ta - tr), W'(LAT + 1));
        chk("p1_read_mre", W'(nre - n0), W'(LAT));

        n0 = nwe;
        xact(0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, rd, tr, ta);
        chk("p0_write_rdata", rd, '0);
        chk("p0_write_mwe", W'(nwe - n0), W'(1));
        xact(0, 1'b0, 32'h0000_0020, '0, 1'b0, rd, tr, ta);
        chk("p0_readback", rd, 32'hDEAD_BEEF);

        xact(0, 1'b0, 32'h0000_0020, '0, 1'b1, rd, tr, ta);
        chk("drop_data", rd, 32'hDEAD_BEEF);
        chk("drop_lat", W'(ta - tr), W'(LAT + 1));

        // Held request: a req still high in IDLE is granted immediately.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h0000_0010, '0);
        na = 0;
        for (int k = 0; k < 60 && na < 3; k++) begin
            @(negedge clk);
            if (p1_ack) begin acks[na] = cyc; na++; end
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, '0, '0);
        chk("held_acks", W'(na), W'(3));
        chk("held_gap0", W'(acks[1] - acks[0]), W'(LAT + 2));
        chk("held_gap1", W'(acks[2] - acks[1]), W'(LAT + 2));

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        g0 = glog.size();
        fork
            begin
                logic [W-1:0] r0; int a0, b0;
                for (int i = 0; i < 2; i++) xact(0, 1'b0, W'(i * 8), '0, 1'b0, r0, a0, b0);
            end
            begin
                logic [W-1:0] r1; int a1, b1;
                for (int i = 0; i < 2; i++) xact(1, 1'b0, W'(i * 8 + 4), '0, 1'b0, r1, a1, b1);
            end
        join
        chk("rr_count", W'(glog.size() - g0), W'(4));
        if (glog.size() >= g0 + 4)
            for (int i = 0; i < 4; i++) chk("rr_order", W'(glog[g0 + i]), W'(i % 2));

        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h0000_0010, '0);
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("abort_busy", W'(busy), '0);
        chk("abort_ack", W'(p1_ack), '0);
        chk("abort_mem", m_addr | m_wdata | W'({m_we, m_re}), '0);
        repeat (4) @(negedge clk);

        fork
            begin
                logic [W-1:0] r0; int a0, b0;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    xact(0, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)) << 2, $urandom,
                         $urandom_range(0, 3) == 0, r0, a0, b0);
                end
            end
            begin
                logic [W-1:0] r1; int a1, b1;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    xact(1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)) << 2, $urandom,
                         $urandom_range(0, 3) == 0, r1, a1, b1);
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("sb_drained", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
